// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-stream traffic source.
// Emits byte-wide frames whose payload is the 1-based beat index, with
// programmable length, frame count, inter-frame gap and end-of-frame mty.
// A mid-frame abort shortens the frame and flags its final beat as dropped.
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int MTY_WIDTH  = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  abort_req,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic [15:0]           cfg_pkt_num,
  input  logic [7:0]            cfg_ifg,
  input  logic [MTY_WIDTH-1:0]  cfg_mty,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [MTY_WIDTH-1:0]  m_axis_tuser_mty,
  input  logic                  m_axis_tready,
  output logic                  m_drop_incmpt_pkt,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  abort_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                state_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  beat_reg;
  logic [15:0]           num_reg;
  logic [15:0]           frame_reg;
  logic [7:0]            ifg_reg;
  logic [7:0]            gap_reg;
  logic [MTY_WIDTH-1:0]  mty_reg;
  logic                  stop_pend_reg;
  logic                  abort_pend_reg;
  logic                  tvalid_reg;
  logic [DATA_WIDTH-1:0] tdata_reg;
  logic                  tlast_reg;
  logic [MTY_WIDTH-1:0]  tmty_reg;
  logic                  drop_reg;
  logic                  busy_reg;
  logic [CNT_WIDTH-1:0]  pkt_cnt_reg;
  logic [CNT_WIDTH-1:0]  abort_cnt_reg;

  logic                  fire;
  logic [LEN_WIDTH-1:0]  start_len;
  logic [LEN_WIDTH-1:0]  next_beat;
  logic                  abort_now;
  logic                  last_frame;

  assign fire       = tvalid_reg && m_axis_tready;
  // A zero length would never reach tlast, so it is promoted to one beat.
  assign start_len  = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
  assign next_beat  = beat_reg + LEN_WIDTH'(1);
  // An abort arriving on the same cycle as a handshake applies to the very next beat.
  assign abort_now  = abort_pend_reg || (abort_req && !tlast_reg);
  assign last_frame = ((num_reg != 16'd0) && (frame_reg + 16'd1 == num_reg))
                      || stop_pend_reg || stop;

  // Frame sequencer: all AXIS outputs and status counters are registered here.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      beat_reg       <= '0;
      num_reg        <= '0;
      frame_reg      <= '0;
      ifg_reg        <= '0;
      gap_reg        <= '0;
      mty_reg        <= '0;
      stop_pend_reg  <= 1'b0;
      abort_pend_reg <= 1'b0;
      tvalid_reg     <= 1'b0;
      tdata_reg      <= '0;
      tlast_reg      <= 1'b0;
      tmty_reg       <= '0;
      drop_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      pkt_cnt_reg    <= '0;
      abort_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg        <= start_len;
            num_reg        <= cfg_pkt_num;
            ifg_reg        <= cfg_ifg;
            mty_reg        <= cfg_mty;
            frame_reg      <= '0;
            // start together with stop: run exactly one frame
            stop_pend_reg  <= stop;
            abort_pend_reg <= 1'b0;
            state_reg      <= SEND;
            busy_reg       <= 1'b1;
            tvalid_reg     <= 1'b1;
            beat_reg       <= LEN_WIDTH'(1);
            tdata_reg      <= DATA_WIDTH'(1);
            tlast_reg      <= (start_len == LEN_WIDTH'(1));
            tmty_reg       <= (start_len == LEN_WIDTH'(1)) ? cfg_mty : '0;
            drop_reg       <= 1'b0;
          end
        end

        SEND: begin
          if (stop) stop_pend_reg <= 1'b1;
          if (fire) begin
            if (tlast_reg) begin
              pkt_cnt_reg    <= pkt_cnt_reg + CNT_WIDTH'(1);
              if (drop_reg) abort_cnt_reg <= abort_cnt_reg + CNT_WIDTH'(1);
              frame_reg      <= frame_reg + 16'd1;
              abort_pend_reg <= 1'b0;
              drop_reg       <= 1'b0;
              if (last_frame) begin
                state_reg     <= IDLE;
                busy_reg      <= 1'b0;
                stop_pend_reg <= 1'b0;
                tvalid_reg    <= 1'b0;
                tdata_reg     <= '0;
                tlast_reg     <= 1'b0;
                tmty_reg      <= '0;
              end else if (ifg_reg == 8'd0) begin
                beat_reg  <= LEN_WIDTH'(1);
                tdata_reg <= DATA_WIDTH'(1);
                tlast_reg <= (len_reg == LEN_WIDTH'(1));
                tmty_reg  <= (len_reg == LEN_WIDTH'(1)) ? mty_reg : '0;
              end else begin
                state_reg  <= GAP;
                gap_reg    <= ifg_reg;
                tvalid_reg <= 1'b0;
                tdata_reg  <= '0;
                tlast_reg  <= 1'b0;
                tmty_reg   <= '0;
              end
            end else begin
              beat_reg  <= next_beat;
              tdata_reg <= DATA_WIDTH'(next_beat);
              if (abort_now) begin
                tlast_reg      <= 1'b1;
                tmty_reg       <= mty_reg;
                drop_reg       <= 1'b1;
                abort_pend_reg <= 1'b0;
              end else begin
                tlast_reg <= (next_beat == len_reg);
                tmty_reg  <= (next_beat == len_reg) ? mty_reg : '0;
                drop_reg  <= 1'b0;
              end
            end
          end else if (abort_req && !tlast_reg) begin
            // beat is stalled: defer the abort so the presented beat stays stable
            abort_pend_reg <= 1'b1;
          end
        end

        GAP: begin
          if (stop) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            stop_pend_reg <= 1'b0;
          end else if (gap_reg == 8'd1) begin
            state_reg  <= SEND;
            tvalid_reg <= 1'b1;
            beat_reg   <= LEN_WIDTH'(1);
            tdata_reg  <= DATA_WIDTH'(1);
            tlast_reg  <= (len_reg == LEN_WIDTH'(1));
            tmty_reg   <= (len_reg == LEN_WIDTH'(1)) ? mty_reg : '0;
            drop_reg   <= 1'b0;
          end else begin
            gap_reg <= gap_reg - 8'd1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_axis_tvalid     = tvalid_reg;
  assign m_axis_tdata      = tdata_reg;
  assign m_axis_tlast      = tlast_reg;
  assign m_axis_tuser_mty  = tmty_reg;
  assign m_drop_incmpt_pkt = drop_reg;
  assign busy              = busy_reg;
  assign pkt_cnt           = pkt_cnt_reg;
  assign abort_cnt         = abort_cnt_reg;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: table-driven configurations, hand-written abort/stop/reset
// sequences, and randomized back-pressure runs checked against a frame-list model.
module tb_axis_pkt_gen;
  localparam int DW = 8;
  localparam int MW = 8;
  localparam int LW = 16;
  localparam int CW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          abort_req = 1'b0;
  logic [LW-1:0] cfg_pkt_len = '0;
  logic [15:0]   cfg_pkt_num = '0;
  logic [7:0]    cfg_ifg = '0;
  logic [MW-1:0] cfg_mty = '0;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic [MW-1:0] tmty;
  logic          tready = 1'b1;
  logic          drop;
  logic          busy;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] abort_cnt;

  axis_pkt_gen #(.DATA_WIDTH(DW), .MTY_WIDTH(MW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .areset(areset), .start(start), .stop(stop), .abort_req(abort_req),
    .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_num(cfg_pkt_num), .cfg_ifg(cfg_ifg), .cfg_mty(cfg_mty),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tlast(tlast),
    .m_axis_tuser_mty(tmty), .m_axis_tready(tready), .m_drop_incmpt_pkt(drop),
    .busy(busy), .pkt_cnt(pkt_cnt), .abort_cnt(abort_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [MW-1:0] mty;
    logic          drop;
  } beat_t;

  // ---------------- monitor: accepted beats, busy/idle cycles, AXIS stability
  beat_t acc_q[$];
  beat_t cur_beat;
  beat_t prev_beat;
  logic  prev_stall;
  logic  mon_clr = 1'b0;
  int    busy_cyc;
  int    idle_cyc;
  int    stab_err;

  assign cur_beat = {tdata, tlast, tmty, drop};

  // Sampled on the falling edge, away from the DUT's active edge.
  always @(negedge aclk) begin
    if (mon_clr) begin
      acc_q.delete();
      busy_cyc   <= 0;
      idle_cyc   <= 0;
      stab_err   <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (busy) busy_cyc <= busy_cyc + 1;
      if (busy && !tvalid) idle_cyc <= idle_cyc + 1;
      if (prev_stall && (!tvalid || cur_beat != prev_beat)) stab_err <= stab_err + 1;
      if (tvalid && tready) acc_q.push_back(cur_beat);
      prev_stall <= tvalid && !tready;
      prev_beat  <= cur_beat;
    end
  end

  // ---------------- checking helpers
  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic set_cfg(input int len, input int num, input int ifg, input logic [7:0] mty);
    cfg_pkt_len = LW'(len);
    cfg_pkt_num = 16'(num);
    cfg_ifg     = 8'(ifg);
    cfg_mty     = mty;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge aclk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // ---------------- directed configuration table
  typedef struct {
    int         len;
    int         num;
    int         ifg;
    logic [7:0] mty;
    int         cyc;    // busy cycles: num*len + (num-1)*ifg
    int         beats;  // accepted beats
    int         pkts;   // pkt_cnt afterwards
  } vec_t;

  vec_t  vecs[7];
  beat_t exp_q[$];

  initial begin
    int    bad;
    int    L;
    int    r_len, r_num, r_ifg;
    logic [7:0] r_mty;
    beat_t e;

    vecs[0] = '{12,  1, 0, 8'h01,  12,  12, 1};
    vecs[1] = '{12,  3, 0, 8'h02,  36,  36, 3};
    vecs[2] = '{12,  2, 4, 8'h03,  28,  24, 2};
    vecs[3] = '{ 1,  3, 0, 8'h05,   3,   3, 3};
    vecs[4] = '{ 0,  2, 1, 8'h07,   3,   2, 2};
    vecs[5] = '{ 5,  2, 2, 8'hA5,  12,  10, 2};
    vecs[6] = '{300, 1, 0, 8'h11, 300, 300, 1};

    // reset state
    do_reset();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_mty", tmty, 0);
    chk("rst_drop", drop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_abort_cnt", abort_cnt, 0);
    $display("[TB] reset state checked");

    // table-driven runs with tready held high
    for (int v = 0; v < 7; v++) begin
      do_reset();
      set_cfg(vecs[v].len, vecs[v].num, vecs[v].ifg, vecs[v].mty);
      tready = 1'b1;
      clear_mon();
      do_start();
      wait_idle(2000);
      chk("vec_busy_cycles", busy_cyc, vecs[v].cyc);
      chk("vec_beats", acc_q.size(), vecs[v].beats);
      chk("vec_pkt_cnt", pkt_cnt, vecs[v].pkts);
      L = (vecs[v].len == 0) ? 1 : vecs[v].len;
      bad = 0;
      for (int i = 0; i < acc_q.size(); i++) begin
        e = {8'((i % L) + 1), ((i % L) == L - 1), (((i % L) == L - 1) ? vecs[v].mty : 8'h00), 1'b0};
        if (acc_q[i] != e) bad++;
      end
      chk("vec_beat_seq", bad, 0);
      $display("[TB] vec %0d len=%0d num=%0d ifg=%0d: %0d beats in %0d busy cycles",
               v, vecs[v].len, vecs[v].num, vecs[v].ifg, acc_q.size(), busy_cyc);
    end

    // back-pressure: hold 0x05 for two cycles
    do_reset();
    set_cfg(12, 1, 0, 8'h01);
    clear_mon();
    do_start();
    repeat (4) tick();
    chk("stall_pre_data", tdata, 5);
    tready = 1'b0;
    tick();
    chk("stall_hold1", {tvalid, tdata, tlast}, {1'b1, 8'h05, 1'b0});
    tick();
    chk("stall_hold2", {tvalid, tdata, tlast}, {1'b1, 8'h05, 1'b0});
    tready = 1'b1;
    wait_idle(100);
    chk("stall_cycles", busy_cyc, 14);
    chk("stall_beats", acc_q.size(), 12);
    bad = 0;
    for (int i = 0; i < acc_q.size(); i++) if (acc_q[i].data != 8'(i + 1)) bad++;
    chk("stall_seq", bad, 0);
    chk("stall_stability", stab_err, 0);
    $display("[TB] stall sequence: %0d beats in %0d cycles", acc_q.size(), busy_cyc);

    // continuous run: abort at 0x05, then stop during frame 3
    do_reset();
    set_cfg(12, 0, 0, 8'h33);
    clear_mon();
    do_start();
    repeat (4) tick();
    chk("abort_pre_data", tdata, 5);
    abort_req = 1'b1;
    tick();
    abort_req = 1'b0;
    chk("abort_beat", {tdata, tlast, tmty, drop}, {8'h06, 1'b1, 8'h33, 1'b1});
    tick();
    chk("abort_next_frame", {tvalid, tdata, tlast, drop}, {1'b1, 8'h01, 1'b0, 1'b0});
    chk("abort_cnt_1", abort_cnt, 1);
    chk("abort_pkt_cnt_1", pkt_cnt, 1);
    repeat (12) tick();
    chk("frame3_start", {tvalid, tdata}, {1'b1, 8'h01});
    chk("frame3_pkt_cnt", pkt_cnt, 2);
    repeat (2) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle(50);
    chk("stop_pkt_cnt", pkt_cnt, 3);
    chk("stop_abort_cnt", abort_cnt, 1);
    chk("stop_beats", acc_q.size(), 30);
    chk("stop_tvalid", tvalid, 0);
    $display("[TB] abort+stop sequence: pkt_cnt=%0d abort_cnt=%0d", pkt_cnt, abort_cnt);

    // abort requested while the beat is stalled
    do_reset();
    set_cfg(12, 1, 0, 8'h44);
    clear_mon();
    do_start();
    repeat (4) tick();
    tready = 1'b0;
    abort_req = 1'b1;
    tick();
    abort_req = 1'b0;
    chk("abort_stall_hold", {tdata, tlast, drop}, {8'h05, 1'b0, 1'b0});
    tready = 1'b1;
    tick();
    chk("abort_stall_beat", {tdata, tlast, tmty, drop}, {8'h06, 1'b1, 8'h44, 1'b1});
    tick();
    chk("abort_stall_idle", busy, 0);
    chk("abort_stall_cnt", abort_cnt, 1);
    $display("[TB] stalled abort sequence done");

    // abort on a tlast beat is ignored
    do_reset();
    set_cfg(4, 2, 0, 8'h55);
    clear_mon();
    do_start();
    repeat (3) tick();
    chk("last_pre", {tdata, tlast}, {8'h04, 1'b1});
    abort_req = 1'b1;
    tick();
    abort_req = 1'b0;
    chk("abort_on_last_ignored", {tdata, tlast, drop}, {8'h01, 1'b0, 1'b0});
    repeat (3) tick();
    chk("frame2_last", {tdata, tlast, tmty, drop}, {8'h04, 1'b1, 8'h55, 1'b0});
    tick();
    chk("frame2_idle", busy, 0);
    chk("ignored_abort_cnt", abort_cnt, 0);
    $display("[TB] abort on tlast sequence done");

    // abort on the second-to-last beat keeps the frame length
    do_reset();
    set_cfg(12, 1, 0, 8'h66);
    clear_mon();
    do_start();
    repeat (10) tick();
    chk("penult_pre", tdata, 11);
    abort_req = 1'b1;
    tick();
    abort_req = 1'b0;
    chk("penult_beat", {tdata, tlast, tmty, drop}, {8'h0C, 1'b1, 8'h66, 1'b1});
    tick();
    chk("penult_beats", acc_q.size(), 12);
    $display("[TB] second-to-last abort sequence done");

    // reset in the middle of a frame (counters are nonzero beforehand)
    set_cfg(12, 1, 0, 8'h01);
    do_start();
    repeat (6) tick();
    chk("rst_mid_pre", tdata, 7);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("rst_mid_outputs", {tvalid, tdata, tlast, tmty, drop, busy}, 0);
    chk("rst_mid_pkt_cnt", pkt_cnt, 0);
    chk("rst_mid_abort_cnt", abort_cnt, 0);
    do_start();
    chk("rst_restart", {tvalid, tdata, busy}, {1'b1, 8'h01, 1'b1});
    wait_idle(50);
    $display("[TB] mid-frame reset sequence done");

    // start and stop together in IDLE: exactly one frame
    do_reset();
    set_cfg(3, 0, 0, 8'h07);
    clear_mon();
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    wait_idle(50);
    chk("startstop_pkt_cnt", pkt_cnt, 1);
    chk("startstop_beats", acc_q.size(), 3);
    $display("[TB] start+stop sequence done");

    // stop during the gap ends the run on the next edge
    do_reset();
    set_cfg(3, 0, 5, 8'h07);
    do_start();
    repeat (3) tick();
    chk("gap_entered", {busy, tvalid}, {1'b1, 1'b0});
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("gap_stop_idle", busy, 0);
    chk("gap_stop_pkt_cnt", pkt_cnt, 1);
    $display("[TB] stop in gap sequence done");

    // randomized back-pressure runs against a frame-list model
    for (int r = 0; r < 8; r++) begin
      int n;
      do_reset();
      r_len = $urandom_range(1, 20);
      r_num = $urandom_range(1, 4);
      r_ifg = $urandom_range(0, 3);
      r_mty = 8'($urandom_range(1, 255));
      exp_q.delete();
      for (int f = 0; f < r_num; f++)
        for (int b = 1; b <= r_len; b++)
          exp_q.push_back({8'(b), (b == r_len), ((b == r_len) ? r_mty : 8'h00), 1'b0});
      set_cfg(r_len, r_num, r_ifg, r_mty);
      tready = 1'b1;
      clear_mon();
      do_start();
      n = 0;
      while (busy && n < 3000) begin
        tready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) begin
          // start while busy must be ignored, even with different config
          start = 1'b1;
          cfg_pkt_len = LW'($urandom_range(1, 20));
          cfg_pkt_num = 16'($urandom_range(0, 4));
        end
        tick();
        start = 1'b0;
        n++;
      end
      tready = 1'b1;
      chk("rand_timeout", busy, 0);
      chk("rand_beats", acc_q.size(), exp_q.size());
      bad = 0;
      for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
        if (acc_q[i] != exp_q[i]) bad++;
      chk("rand_beat_seq", bad, 0);
      chk("rand_gap_cycles", idle_cyc, (r_num - 1) * r_ifg);
      chk("rand_pkt_cnt", pkt_cnt, r_num);
      chk("rand_stability", stab_err, 0);
      $display("[TB] rand %0d len=%0d num=%0d ifg=%0d: %0d beats, %0d gap cycles",
               r, r_len, r_num, r_ifg, acc_q.size(), idle_cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
